// File: rtl/pulse_burst_gen_pkg.sv
// Shared definitions for the pulse generator and its companion pulse counter:
// FSM state encoding, minimum pulse spacing and default field widths.
package pulse_pkg;

    localparam int DEF_PERIOD_WIDTH = 16;
    localparam int DEF_COUNT_WIDTH  = 8;
    localparam int MIN_PERIOD       = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } pulse_state_e;

endpackage

// File: rtl/pulse_burst_gen_if.sv
// Request/status bundle of the pulse burst generator; the master side issues
// bursts, the slave side (the generator) produces the pulse train and status.
interface pulse_burst_gen_if
    import pulse_pkg::*;
#(
    parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH
) ();

    logic                    start;
    logic                    stop;
    logic [PERIOD_WIDTH-1:0] period;
    logic [COUNT_WIDTH-1:0]  burst_len;
    logic                    pulse_out;
    logic                    busy;
    logic                    done;
    logic [COUNT_WIDTH-1:0]  pulses_sent;

    modport master (
        output start, stop, period, burst_len,
        input  pulse_out, busy, done, pulses_sent
    );

    modport slave (
        input  start, stop, period, burst_len,
        output pulse_out, busy, done, pulses_sent
    );

endinterface

// File: rtl/pulse_burst_gen_period_timer.sv
// Loadable down-counter that spaces the pulses; expire_o flags the terminal
// count of zero, where the counter parks instead of wrapping.
module pulse_period_timer
    import pulse_pkg::*;
#(
    parameter int WIDTH = DEF_PERIOD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expire_o = (count_q == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// Programmable pulse-train generator: burst_len one-cycle pulses spaced
// max(period,2) clocks apart. Define PULSE_GEN_CONT_EN for continuous mode.
module pulse_burst_gen
    import pulse_pkg::*;
#(
    parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    pulse_burst_gen_if.slave bus
);

    localparam logic [PERIOD_WIDTH-1:0] MinPeriod = PERIOD_WIDTH'(MIN_PERIOD);

    pulse_state_e            state_q;
    logic                    pulseOut_q;
    logic                    busy_q;
    logic                    done_q;
    logic [COUNT_WIDTH-1:0]  sent_q;
    logic [COUNT_WIDTH-1:0]  sent_d;
    logic [COUNT_WIDTH-1:0]  burstLen_q;
    logic [PERIOD_WIDTH-1:0] periodEff_q;
    logic [PERIOD_WIDTH-1:0] periodEff_d;
    logic [PERIOD_WIDTH-1:0] timerLoadValue;
    logic                    timerLoad;
    logic                    timerExpire;
    logic                    lastPulse;
`ifdef PULSE_GEN_CONT_EN
    logic                    cont_q;
`endif

    assign periodEff_d = (bus.period < MinPeriod) ? MinPeriod : bus.period;
    assign sent_d      = (sent_q == '1) ? sent_q : sent_q + 1'b1;

`ifdef PULSE_GEN_CONT_EN
    assign lastPulse = !cont_q && (sent_d == burstLen_q);
`else
    assign lastPulse = (sent_d == burstLen_q);
`endif

    // Reloaded during each pulse cycle, so it reaches zero Peff-1 cycles later
    // and the next registered pulse lands exactly Peff cycles after this one.
    assign timerLoad      = (state_q == RUN) && pulseOut_q;
    assign timerLoadValue = periodEff_q - MinPeriod;

    pulse_period_timer #(
        .WIDTH (PERIOD_WIDTH)
    ) uTimer (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (timerLoad),
        .load_value_i (timerLoadValue),
        .expire_o     (timerExpire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pulseOut_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sent_q      <= '0;
            burstLen_q  <= '0;
            periodEff_q <= '0;
`ifdef PULSE_GEN_CONT_EN
            cont_q      <= 1'b0;
`endif
        end else begin
            pulseOut_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        periodEff_q <= periodEff_d;
                        burstLen_q  <= bus.burst_len;
                        sent_q      <= '0;
                        if (bus.burst_len != '0) begin
                            state_q    <= RUN;
                            busy_q     <= 1'b1;
                            pulseOut_q <= 1'b1;
`ifdef PULSE_GEN_CONT_EN
                            cont_q     <= 1'b0;
`endif
                        end
`ifdef PULSE_GEN_CONT_EN
                        else begin
                            state_q    <= RUN;
                            busy_q     <= 1'b1;
                            pulseOut_q <= 1'b1;
                            cont_q     <= 1'b1;
                        end
`else
                        else begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    // A pulse already on the output is counted even when aborted.
                    if (pulseOut_q) begin
                        sent_q <= sent_d;
                    end
                    if (bus.stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`ifdef PULSE_GEN_CONT_EN
                        cont_q  <= 1'b0;
`endif
                    end else if (pulseOut_q && lastPulse) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (!pulseOut_q && timerExpire) begin
                        pulseOut_q <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pulse_out   = pulseOut_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pulses_sent = sent_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Self-checking bench for pulse_burst_gen: directed burst table, hand-written
// corner sequences and random traffic against a schedule-based reference model.
module tb_pulse_burst_gen;
    import pulse_pkg::*;

    localparam int PW      = 16;
    localparam int CW      = 8;
    localparam int INF     = 1000000000;
    localparam int SentMax = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   monEn  = 1'b0;

    always #5 clk = ~clk;

    pulse_burst_gen_if #(.PERIOD_WIDTH(PW), .COUNT_WIDTH(CW)) bus ();

    pulse_burst_gen #(
        .PERIOD_WIDTH (PW),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: the accepted burst is described by its start cycle,
    // effective period, length and the cycle of an honoured stop; every output
    // is derived arithmetically from that schedule.
    bit mHas  = 1'b0;
    bit mCont = 1'b0;
    int mT    = 0;
    int mPeff = 2;
    int mLen  = 0;
    int mStop = INF;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int mLastPulse();
        if (mCont) return INF;
        if (mLen == 0) return mT;
        return mT + 1 + (mLen - 1) * mPeff;
    endfunction

    function automatic int mEnd();
        return imin(mLastPulse(), mStop);
    endfunction

    function automatic int mIdleFrom();
        if (!mHas) return 0;
        if (mStop != INF) return mStop + 1;
        if (mCont) return INF;
        return mLastPulse() + 2;
    endfunction

    function automatic int expPulse(input int c);
        if (!mHas || c < mT + 1 || c > mEnd()) return 0;
        return ((c - mT - 1) % mPeff == 0) ? 1 : 0;
    endfunction

    function automatic int expBusy(input int c);
        if (!mHas || c < mT + 1 || c > mEnd()) return 0;
        return 1;
    endfunction

    function automatic int expDone(input int c);
        if (!mHas || mCont || mStop != INF) return 0;
        return (c == mLastPulse() + 1) ? 1 : 0;
    endfunction

    function automatic int expSent(input int c);
        int lim;
        if (!mHas) return 0;
        lim = imin(c - 1, mEnd());
        if (lim < mT + 1) return 0;
        return imin((lim - mT - 1) / mPeff + 1, SentMax);
    endfunction

    task automatic modelStep(input bit s, input bit p, input int per, input int len);
        if (s && !p && cyc >= mIdleFrom()) begin
            mHas  = 1'b1;
            mT    = cyc;
            mPeff = (per < MIN_PERIOD) ? MIN_PERIOD : per;
            mLen  = len;
            mStop = INF;
`ifdef PULSE_GEN_CONT_EN
            mCont = (len == 0);
`else
            mCont = 1'b0;
`endif
        end else if (p && mHas && cyc >= mT + 1 && cyc <= mLastPulse() && mStop == INF) begin
            mStop = cyc;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // One cycle of inputs, driven at the falling edge and mirrored into the model.
    task automatic applyStimulus(input bit s, input bit p, input int per, input int len);
        @(negedge clk);
        bus.start     = s;
        bus.stop      = p;
        bus.period    = PW'(per);
        bus.burst_len = CW'(len);
        modelStep(s, p, per % (1 << PW), len % (1 << CW));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 0);
    endtask

    task automatic runBurst(input int per, input int len, input int stopAfter, input int reStartAt,
                            output int pulses, output int doneOff, output bit finished);
        int  tStart;
        bit  stopPending;
        applyStimulus(1'b1, 1'b0, per, len);
        tStart      = cyc;
        pulses      = 0;
        doneOff     = -1;
        finished    = 1'b0;
        stopPending = 1'b0;
        for (int i = 0; i < 300 && !finished; i++) begin
            if (i == reStartAt) applyStimulus(1'b1, 1'b0, per + 5, len + 3);
            else                applyStimulus(1'b0, stopPending, per, len);
            stopPending = 1'b0;
            if (bus.pulse_out === 1'b1) begin
                pulses++;
                if (stopAfter != 0 && pulses == stopAfter) stopPending = 1'b1;
            end
            if (bus.done === 1'b1) doneOff = cyc - tStart;
            if (cyc > tStart + 1 && bus.busy === 1'b0 && bus.done === 1'b0) finished = 1'b1;
        end
    endtask

    // Every cycle the DUT outputs are compared against the schedule model.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (monEn) begin
            checkOutput("mon_pulse_out", int'(bus.pulse_out), expPulse(cyc));
            checkOutput("mon_busy", int'(bus.busy), expBusy(cyc));
            checkOutput("mon_done", int'(bus.done), expDone(cyc));
            checkOutput("mon_pulses_sent", int'(bus.pulses_sent), expSent(cyc));
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        int period;
        int len;
        int stopAfter;
        int expPulses;
        int expDoneOff;
        int expSent;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   pulses;
        int   doneOff;
        bit   finished;
        int   busyCycles;

        vecs.push_back(vec_t'{4, 3, 0, 3, 10, 3});
        vecs.push_back(vec_t'{1, 2, 0, 2, 4, 2});
        vecs.push_back(vec_t'{0, 1, 0, 1, 2, 1});
        vecs.push_back(vec_t'{5, 10, 3, 3, -1, 3});
        vecs.push_back(vec_t'{3, 4, 0, 4, 11, 4});
        vecs.push_back(vec_t'{7, 2, 1, 1, -1, 1});
        vecs.push_back(vec_t'{2, 5, 0, 5, 10, 5});
`ifndef PULSE_GEN_CONT_EN
        vecs.push_back(vec_t'{6, 0, 0, 0, 1, 0});
`endif

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.period    = '0;
        bus.burst_len = '0;
        monEn         = 1'b1;

        idleCycles(2);
        checkOutput("reset_pulse_out", int'(bus.pulse_out), 0);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_done", int'(bus.done), 0);
        checkOutput("reset_pulses_sent", int'(bus.pulses_sent), 0);
        rst_n = 1'b1;
        idleCycles(2);

        $display("[TB] directed burst table");
        foreach (vecs[i]) begin
            idleCycles(2);
            runBurst(vecs[i].period, vecs[i].len, vecs[i].stopAfter, -1, pulses, doneOff, finished);
            checkOutput($sformatf("vec%0d_finished", i), int'(finished), 1);
            checkOutput($sformatf("vec%0d_pulses", i), pulses, vecs[i].expPulses);
            checkOutput($sformatf("vec%0d_done_offset", i), doneOff, vecs[i].expDoneOff);
            checkOutput($sformatf("vec%0d_pulses_sent", i), int'(bus.pulses_sent), vecs[i].expSent);
        end

        $display("[TB] start re-issued while busy");
        idleCycles(2);
        runBurst(4, 3, 0, 3, pulses, doneOff, finished);
        checkOutput("restart_pulses", pulses, 3);
        checkOutput("restart_done_offset", doneOff, 10);

        $display("[TB] start and stop together in IDLE");
        idleCycles(2);
        applyStimulus(1'b1, 1'b1, 3, 2);
        busyCycles = 0;
        for (int i = 0; i < 6; i++) begin
            idleCycles(1);
            if (bus.busy === 1'b1 || bus.pulse_out === 1'b1) busyCycles++;
        end
        checkOutput("start_stop_no_burst", busyCycles, 0);

        $display("[TB] reset in the middle of a burst");
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, 8, 4);
        pulses = 0;
        for (int i = 0; i < 40 && pulses < 2; i++) begin
            idleCycles(1);
            if (bus.pulse_out === 1'b1) pulses++;
        end
        checkOutput("midreset_two_pulses_seen", pulses, 2);
        idleCycles(2);
        rst_n = 1'b0;
        mHas  = 1'b0;
        #1;
        checkOutput("midreset_busy", int'(bus.busy), 0);
        checkOutput("midreset_pulse_out", int'(bus.pulse_out), 0);
        checkOutput("midreset_pulses_sent", int'(bus.pulses_sent), 0);
        checkOutput("midreset_done", int'(bus.done), 0);
        idleCycles(3);
        rst_n = 1'b1;
        idleCycles(1);
        runBurst(8, 4, 0, -1, pulses, doneOff, finished);
        checkOutput("postreset_pulses", pulses, 4);
        checkOutput("postreset_done_offset", doneOff, 26);
        checkOutput("postreset_pulses_sent", int'(bus.pulses_sent), 4);

        $display("[TB] maximum period, aborted in the gap");
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, (1 << PW) - 1, 2);
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            idleCycles(1);
            if (bus.pulse_out === 1'b1) pulses++;
        end
        applyStimulus(1'b0, 1'b1, 0, 0);
        idleCycles(3);
        checkOutput("maxperiod_pulses", pulses, 1);
        checkOutput("maxperiod_busy_after_stop", int'(bus.busy), 0);
        checkOutput("maxperiod_pulses_sent", int'(bus.pulses_sent), 1);

        $display("[TB] random traffic against the reference model");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0,
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 5)));
        end
        applyStimulus(1'b0, 1'b1, 0, 0);
        idleCycles(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
